// File: rtl/ariane_pkg.sv
// ariane_pkg (issue-queue slice)
// Purpose : shared types for the decode -> issue path. Defines the functional
//           unit encoding, the scoreboard entry carried through the issue
//           queue, the issue-queue storage tuple, the default queue depth and
//           the memory-op classifier used by the queue's mem-op counter.
// Ports   : none (package).
package ariane_pkg;

   localparam int unsigned ISSUE_QUEUE_DEPTH = 4;

   typedef enum logic [3:0] {
      NONE      = 4'd0,
      LOAD      = 4'd1,
      STORE     = 4'd2,
      ALU       = 4'd3,
      CTRL_FLOW = 4'd4,
      MULT      = 4'd5,
      CSR       = 4'd6,
      FPU       = 4'd7
   } fu_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  trans_id;
      fu_t         fu;
      logic [6:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        valid;
   } scoreboard_entry_t;

   // One queue slot: the decoded entry plus its control-flow flag.
   typedef struct packed {
      scoreboard_entry_t sbe;
      logic              is_ctrl_flow;
   } issue_queue_entry_t;

   function automatic logic is_mem_op(input fu_t fu);
      return (fu == LOAD) || (fu == STORE);
   endfunction

endpackage

// File: rtl/issue_entry_queue.sv
// issue_entry_queue
// Purpose : decoded-instruction FIFO between decode and the issue-side
//           load/store reorder stage. Holds up to DEPTH entries, exports the
//           head and the entry behind it (peek), the occupancy and the number
//           of queued LOAD/STORE entries.
// Config  : ISSUE_QUEUE_BYPASS_EN - when defined, an entry offered to an empty
//           queue is presented on the head outputs in the same cycle; if it is
//           also consumed that cycle it is never written.
// Ports   :
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  synchronous flush of all entries
//   debug_req_i              blocks enqueue, draining continues
//   decoded_entry_i/_valid_i/_is_ctrl_flow_i, decoded_ack_o
//                            enqueue side
//   issue_entry_o/_valid_o, is_ctrl_flow_o, issue_instr_ack_i
//                            head (dequeue) side
//   peek_entry_o, peek_valid_o  entry at head+1
//   usage_o, mem_ops_o       occupancy and queued memory-op count
// Handshake: an entry moves when valid and ack/ready are both high on the same
//   rising edge. Enqueue: decoded_valid_i & decoded_ack_o. Dequeue:
//   issue_entry_valid_o & issue_instr_ack_i. decoded_ack_o depends only on
//   registered occupancy, debug_req_i and flush_i (never on issue_instr_ack_i).
module issue_entry_queue
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH = ISSUE_QUEUE_DEPTH,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   input  logic                          debug_req_i,
   input  ariane_pkg::scoreboard_entry_t decoded_entry_i,
   input  logic                          decoded_valid_i,
   input  logic                          decoded_is_ctrl_flow_i,
   output logic                          decoded_ack_o,
   output ariane_pkg::scoreboard_entry_t issue_entry_o,
   output logic                          issue_entry_valid_o,
   output logic                          is_ctrl_flow_o,
   input  logic                          issue_instr_ack_i,
   output ariane_pkg::scoreboard_entry_t peek_entry_o,
   output logic                          peek_valid_o,
   output logic [CNT_W-1:0]              usage_o,
   output logic [CNT_W-1:0]              mem_ops_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   issue_queue_entry_t r_mem [DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_usage;
   logic [CNT_W-1:0]   r_mem_ops;

   issue_queue_entry_t w_in;
   issue_queue_entry_t w_head;
   issue_queue_entry_t w_peek;
   logic [PTR_W-1:0]   w_peek_ptr;
   logic               w_empty;
   logic               w_full;
   logic               w_ack;
   logic               w_push;
   logic               w_bypass;
   logic               w_head_valid;
   logic               w_peek_valid;
   logic               w_pop;
   logic               w_write;
   logic               w_pop_mem;
   logic               w_mem_inc;
   logic               w_mem_dec;

   assign w_in    = '{sbe: decoded_entry_i, is_ctrl_flow: decoded_is_ctrl_flow_i};
   assign w_empty = (r_usage == '0);
   assign w_full  = (r_usage == CNT_W'(DEPTH));

   // Full blocks enqueue even if the head leaves this cycle, keeping the
   // ack free of any path from issue_instr_ack_i.
   assign w_ack  = !w_full && !debug_req_i && !flush_i;
   assign w_push = decoded_valid_i && w_ack;

`ifdef ISSUE_QUEUE_BYPASS_EN
   assign w_bypass = w_empty && w_push;
`else
   assign w_bypass = 1'b0;
`endif

   // Head: stored entry when non-empty, otherwise the bypassed input.
   always_comb begin
      w_head       = '0;
      w_head_valid = 1'b0;
      if (!w_empty) begin
         w_head       = r_mem[r_rd_ptr];
         w_head_valid = 1'b1;
      end else if (w_bypass) begin
         w_head       = w_in;
         w_head_valid = 1'b1;
      end
   end

   assign w_peek_ptr   = r_rd_ptr + PTR_W'(1);
   assign w_peek_valid = (r_usage >= CNT_W'(2));

   always_comb begin
      w_peek = '0;
      if (w_peek_valid) begin
         w_peek = r_mem[w_peek_ptr];
      end
   end

   assign w_pop = w_head_valid && issue_instr_ack_i;

   // A bypassed entry consumed in the same cycle never touches storage, so
   // neither the write nor the array-side pop happens.
   assign w_write   = w_push && !(w_bypass && issue_instr_ack_i);
   assign w_pop_mem = w_pop && !w_empty;

   assign w_mem_inc = w_write && is_mem_op(decoded_entry_i.fu);
   assign w_mem_dec = w_pop_mem && is_mem_op(w_head.sbe.fu);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_usage   <= '0;
         r_mem_ops <= '0;
      end else if (flush_i) begin
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_usage   <= '0;
         r_mem_ops <= '0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_mem) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_write, w_pop_mem})
            2'b10:   r_usage <= r_usage + CNT_W'(1);
            2'b01:   r_usage <= r_usage - CNT_W'(1);
            default: r_usage <= r_usage;
         endcase
         case ({w_mem_inc, w_mem_dec})
            2'b10:   r_mem_ops <= r_mem_ops + CNT_W'(1);
            2'b01:   r_mem_ops <= r_mem_ops - CNT_W'(1);
            default: r_mem_ops <= r_mem_ops;
         endcase
      end
   end

   // Storage needs no reset: every read is qualified by the occupancy.
   always_ff @(posedge clk_i) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= w_in;
      end
   end

   assign decoded_ack_o       = w_ack;
   assign issue_entry_o       = w_head.sbe;
   assign is_ctrl_flow_o      = w_head.is_ctrl_flow;
   assign issue_entry_valid_o = w_head_valid;
   assign peek_entry_o        = w_peek.sbe;
   assign peek_valid_o        = w_peek_valid;
   assign usage_o             = r_usage;
   assign mem_ops_o           = r_mem_ops;

endmodule

// File: tb/tb_issue_entry_queue.sv
// tb_issue_entry_queue
// Purpose : self-checking bench for issue_entry_queue. A reference FIFO
//           (exp_q) is the expected-entry queue; the monitor compares every
//           DUT output against it on the falling edge, pops it when the head
//           is consumed and pushes accepted entries. Directed sequences are
//           followed by randomized traffic and an asynchronous mid-run reset.
// Config  : honours ISSUE_QUEUE_BYPASS_EN the same way the design does.
module tb_issue_entry_queue;
   import ariane_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef ISSUE_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic              flush_i;
   logic              debug_req_i;
   scoreboard_entry_t decoded_entry_i;
   logic              decoded_valid_i;
   logic              decoded_is_ctrl_flow_i;
   logic              decoded_ack_o;
   scoreboard_entry_t issue_entry_o;
   logic              issue_entry_valid_o;
   logic              is_ctrl_flow_o;
   logic              issue_instr_ack_i;
   scoreboard_entry_t peek_entry_o;
   logic              peek_valid_o;
   logic [CNT_W-1:0]  usage_o;
   logic [CNT_W-1:0]  mem_ops_o;

   issue_entry_queue #(.DEPTH(DEPTH)) dut (
      .clk_i                  (clk_i),
      .rst_ni                 (rst_ni),
      .flush_i                (flush_i),
      .debug_req_i            (debug_req_i),
      .decoded_entry_i        (decoded_entry_i),
      .decoded_valid_i        (decoded_valid_i),
      .decoded_is_ctrl_flow_i (decoded_is_ctrl_flow_i),
      .decoded_ack_o          (decoded_ack_o),
      .issue_entry_o          (issue_entry_o),
      .issue_entry_valid_o    (issue_entry_valid_o),
      .is_ctrl_flow_o         (is_ctrl_flow_o),
      .issue_instr_ack_i      (issue_instr_ack_i),
      .peek_entry_o           (peek_entry_o),
      .peek_valid_o           (peek_valid_o),
      .usage_o                (usage_o),
      .mem_ops_o              (mem_ops_o)
   );

   // ---------------- scoreboard ----------------
   localparam int unsigned EW = $bits(issue_queue_entry_t);
   logic [EW-1:0] exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   bit  mon_en = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int count_mem();
      int c;
      c = 0;
      foreach (exp_q[i]) begin
         issue_queue_entry_t e;
         e = exp_q[i];
         if (e.sbe.fu == LOAD || e.sbe.fu == STORE) c++;
      end
      return c;
   endfunction

   // Monitor: inputs are stable here and equal what the next rising edge samples.
   always @(negedge clk_i) begin
      if (mon_en) begin
         int            sz;
         logic          e_ack, e_push, e_hv, e_pop;
         logic [EW-1:0] e_head, e_peek, incoming;
         sz       = exp_q.size();
         incoming = {decoded_entry_i, decoded_is_ctrl_flow_i};
         e_ack    = (sz < DEPTH) && !debug_req_i && !flush_i;
         e_push   = decoded_valid_i && e_ack;
         e_head   = '0;
         e_hv     = 1'b0;
         if (sz > 0) begin
            e_head = exp_q[0];
            e_hv   = 1'b1;
         end else if (BYP && e_push) begin
            e_head = incoming;
            e_hv   = 1'b1;
         end
         e_peek = (sz >= 2) ? exp_q[1] : '0;

         check("decoded_ack",  128'(decoded_ack_o), 128'(e_ack));
         check("head_valid",   128'(issue_entry_valid_o), 128'(e_hv));
         check("head_entry",   128'({issue_entry_o, is_ctrl_flow_o}), 128'(e_head));
         check("peek_valid",   128'(peek_valid_o), 128'(sz >= 2));
         check("peek_entry",   128'({peek_entry_o, 1'b0}), 128'({e_peek[EW-1:1], 1'b0}));
         check("usage",        128'(usage_o), 128'(sz));
         check("mem_ops",      128'(mem_ops_o), 128'(count_mem()));

         e_pop = e_hv && issue_instr_ack_i;
         if (flush_i) begin
            exp_q.delete();
         end else begin
            if (e_pop && sz > 0) void'(exp_q.pop_front());
            if (e_push && !(e_pop && sz == 0)) exp_q.push_back(incoming);
         end
      end
   end

   // ---------------- driver ----------------
   function automatic scoreboard_entry_t mk(input fu_t fu);
      scoreboard_entry_t e;
      e.pc       = $urandom;
      e.trans_id = 3'($urandom_range(0, 7));
      e.fu       = fu;
      e.op       = 7'($urandom_range(0, 127));
      e.rs1      = 5'($urandom_range(0, 31));
      e.rs2      = 5'($urandom_range(0, 31));
      e.rd       = 5'($urandom_range(0, 31));
      e.valid    = 1'b1;
      return e;
   endfunction

   function automatic fu_t rand_fu();
      fu_t tbl [8];
      tbl = '{NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU};
      return tbl[$urandom_range(0, 7)];
   endfunction

   task automatic drive(input logic v, input scoreboard_entry_t e, input logic cf,
                        input logic ack, input logic fl, input logic dbg);
      decoded_valid_i        = v;
      decoded_entry_i        = e;
      decoded_is_ctrl_flow_i = cf;
      issue_instr_ack_i      = ack;
      flush_i                = fl;
      debug_req_i            = dbg;
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 128'(issue_entry_valid_o), 128'(0));
      check({tag, "_head"},  128'(issue_entry_o), 128'(0));
      check({tag, "_peekv"}, 128'(peek_valid_o), 128'(0));
      check({tag, "_usage"}, 128'(usage_o), 128'(0));
      check({tag, "_memops"},128'(mem_ops_o), 128'(0));
      check({tag, "_ack"},   128'(decoded_ack_o), 128'(1));
   endtask

   initial begin
      scoreboard_entry_t e5;
      decoded_valid_i        = 1'b0;
      decoded_entry_i        = '0;
      decoded_is_ctrl_flow_i = 1'b0;
      issue_instr_ack_i      = 1'b0;
      flush_i                = 1'b0;
      debug_req_i            = 1'b0;
      #2;
      check_reset_outputs("reset");
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      mon_en = 1'b1;

      // three ALU entries, then drain in order
      for (int i = 0; i < 3; i++) drive(1'b1, mk(ALU), i[0], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);

      // fill, offer a 5th while popping (refused), accepted next cycle
      for (int i = 0; i < 4; i++) drive(1'b1, mk(ALU), 1'b0, 1'b0, 1'b0, 1'b0);
      e5 = mk(CTRL_FLOW);
      drive(1'b1, e5, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, e5, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);

      // memory-op accounting
      drive(1'b1, mk(LOAD),  1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, mk(ALU),   1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, mk(STORE), 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, mk(LOAD),  1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);

      // flush with a simultaneous push
      drive(1'b1, mk(LOAD), 1'b0, 1'b1, 1'b1, 1'b0);
      idle(1);
      for (int i = 0; i < 3; i++) drive(1'b1, mk(STORE), 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, mk(ALU), 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);

      // debug request drains but blocks enqueue
      for (int i = 0; i < 2; i++) drive(1'b1, mk(ALU), 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, mk(LOAD), 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, mk(LOAD), 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, mk(LOAD), 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, mk(LOAD), 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);

      // empty queue, push and ack together (bypass case)
      drive(1'b1, mk(STORE), 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);

      // randomized traffic with varying backpressure
      for (int i = 0; i < 1500; i++) begin
         int ack_pct;
         ack_pct = ((i / 200) % 2 == 0) ? 30 : 80;
         drive(($urandom_range(0, 99) < 70), mk(rand_fu()), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 99) < ack_pct), ($urandom_range(0, 99) < 3),
               ($urandom_range(0, 99) < 10));
         if (i == 700) begin
            // asynchronous reset mid-operation
            mon_en                 = 1'b0;
            decoded_valid_i        = 1'b0;
            issue_instr_ack_i      = 1'b0;
            flush_i                = 1'b0;
            debug_req_i            = 1'b0;
            rst_ni                 = 1'b0;
            #1;
            check_reset_outputs("midreset");
            exp_q.delete();
            @(posedge clk_i);
            #1;
            rst_ni = 1'b1;
            mon_en = 1'b1;
         end
      end
      idle(2);
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/issue_entry_queue.md
Name: issue_entry_queue

Overview:
- Decoded-instruction queue between the decode stage and the issue-side load/store reorder stage.
- Buffers up to DEPTH scoreboard entries, decoupling decode stalls from issue backpressure.
- Exports head and head+1 (peek) entries plus a count of queued memory ops, so the downstream reorder logic can decide swaps with lookahead.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy and memory-op counters (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush of all entries.
- debug_req_i  in  1  debug request; blocks enqueue.
- decoded_entry_i  in  ariane_pkg::scoreboard_entry_t  entry from decode.
- decoded_valid_i  in  1  decoded_entry_i is valid.
- decoded_is_ctrl_flow_i  in  1  entry is control flow.
- decoded_ack_o  out  1  queue accepts decoded_entry_i this cycle.
- issue_entry_o  out  ariane_pkg::scoreboard_entry_t  head entry.
- issue_entry_valid_o  out  1  head valid.
- is_ctrl_flow_o  out  1  head is control flow.
- issue_instr_ack_i  in  1  downstream consumes head this cycle.
- peek_entry_o  out  ariane_pkg::scoreboard_entry_t  entry behind head.
- peek_valid_o  out  1  peek entry valid (occupancy >= 2).
- usage_o  out  CNT_W  number of queued entries.
- mem_ops_o  out  CNT_W  queued entries with fu == LOAD or STORE.

Behaviour:
- Storage: circular array; rd_ptr and wr_ptr of width $clog2(DEPTH); occupancy counter of CNT_W bits. Pointers wrap modulo DEPTH.
- Each entry stores the tuple {sbe, is_ctrl_flow}.
- push = decoded_valid_i & decoded_ack_o.
- decoded_ack_o = (usage < DEPTH) & !debug_req_i & !flush_i. When full, ack stays low even if the head is popped in the same cycle; there is no combinational path from issue_instr_ack_i to decoded_ack_o.
- pop = issue_entry_valid_o & issue_instr_ack_i. An ack while the head is invalid is ignored.
- Head outputs are driven combinationally from array[rd_ptr]; peek outputs from array[rd_ptr+1].
  - When the head or peek slot is invalid, its outputs are driven to '0.
- Push and pop in the same cycle: usage is unchanged and both pointers advance.
- mem_ops_o: +1 on push of a LOAD/STORE entry, -1 on pop of a LOAD/STORE entry. Both in one cycle nets out; never wraps.
- flush_i:
  - Next cycle: pointers, usage and mem_ops are 0.
  - Flush overrides push and pop in the same cycle; decoded_ack_o is 0 during flush.
  - issue_entry_valid_o still reflects the pre-flush state during the flush cycle.
- debug_req_i: enqueue is held off; the queue keeps draining normally.
- Reset values: all valid outputs 0, entry outputs '0, usage_o = 0, mem_ops_o = 0, decoded_ack_o = 1 (while debug_req_i and flush_i are low). Reset mid-operation discards all entries immediately.
- Latency without bypass: an entry pushed in cycle N is at the head in cycle N+1 at the earliest.

Optional Feature:
- Macro: ISSUE_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is empty and decoded_valid_i & decoded_ack_o, decoded_entry_i and decoded_is_ctrl_flow_i drive the head outputs combinationally in the same cycle (0-cycle latency).
  - If issue_instr_ack_i is also high, the entry is not written and usage and mem_ops are unchanged; otherwise it is written normally.
  - The peek outputs never bypass.
- Undefined: no bypass; head is always array-driven; 1-cycle minimum latency.

Decomposition:
- ariane_pkg supplies scoreboard_entry_t and the fu encodings (LOAD, STORE).
- Add to ariane_pkg:
  - ISSUE_QUEUE_DEPTH constant, default 4.
  - packed struct issue_queue_entry_t {sbe, is_ctrl_flow}.
- No sub-module; pointer/counter logic is inline. The is-memory-op check is a package function is_mem_op(fu).

Test Plan:
- Reset, then push 3 ALU entries on consecutive cycles with issue_instr_ack_i=0 -> usage_o=3, mem_ops_o=0, head=entry0, peek=entry1; ack_i for 3 cycles -> entries in order, usage_o=0.
- Push 4 entries (DEPTH=4), offer a 5th while acking the head -> decoded_ack_o=0 for the 5th in that cycle; it is accepted next cycle; usage_o stays 4 → 3 → 4.
- Push LOAD, ALU, STORE -> mem_ops_o=2; pop LOAD while pushing LOAD -> mem_ops_o stays 2.
- With 3 entries queued, assert flush_i together with a push -> next cycle usage_o=0, issue_entry_valid_o=0, pushed entry discarded.
- Assert debug_req_i with 2 entries queued and decoded_valid_i=1 -> decoded_ack_o=0; 2 pops drain to empty; no new entries enter.
- ISSUE_QUEUE_BYPASS_EN defined: empty queue, push with issue_instr_ack_i=1 -> issue_entry_valid_o=1 in the same cycle, usage_o stays 0. Undefined: same stimulus -> issue_entry_valid_o=0 in that cycle, 1 the next cycle.
